sti_deserializer: RTL and testbench
===================================

Name: sti_deserializer

Overview:
- Receive-side counterpart of the STI serializer: samples a serial bit stream (si_data qualified by si_valid) and rebuilds one frame of 8, 16, 24 or 32 bits.
- Uses the same framing configuration as the transmitter: length, bit order, fill position and low/high byte select.
- Presents the assembled word, the recovered 16-bit payload, and error flags as a one-cycle result strobe.
- Sits in loop-back and verification paths and at the receive end of STI links.

Parameters:
- GAP_ABORT, 1: 1 = si_valid low mid-frame aborts the frame with frame_err; 0 = a gap pauses reception and the bit count holds.

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cfg_load  in  1  latch cfg_* fields; honoured only in IDLE
- cfg_length  in  2  00=8, 01=16, 10=24, 11=32 bits per frame
- cfg_msb  in  1  1 = first bit received is the word MSB; 0 = LSB first
- cfg_fill  in  1  24/32-bit frames: 1 = payload in upper 16 bits, zero pad below; 0 = payload in lower 16 bits, zero pad above
- cfg_low  in  1  8-bit frames: 1 = byte is payload low byte; 0 = high byte
- si_data  in  1  serial data bit
- si_valid  in  1  si_data valid this cycle
- busy  out  1  frame in progress (RECV state)
- po_valid  out  1  one-cycle result strobe
- po_word  out  32  assembled frame, right-aligned, unused upper bits 0
- po_data  out  16  recovered 16-bit payload
- po_length  out  2  cfg_length used for this frame
- pad_err  out  1  valid with po_valid; pad bits of the frame were non-zero
- frame_err  out  1  one-cycle pulse on aborted (short) frame

Behaviour:
- Reset: all outputs 0, config registers 0, shift register and bit counter 0, state IDLE. Reset mid-frame discards the partial frame with no strobe.
- Frame length: N = 8*(cfg_length+1); 6-bit bit counter.
- States:
  - IDLE:
    - cfg_load=1 latches config.
    - si_valid=1 samples bit 1, sets count=1, moves to RECV.
    - cfg_load and si_valid in the same cycle: the new config applies to the frame starting that cycle.
  - RECV:
    - Each si_valid=1 cycle samples one bit and increments count.
    - cfg_load is ignored.
    - When the Nth bit is sampled, go to DONE.
  - DONE:
    - Registered outputs update; po_valid=1 for exactly one cycle, the cycle after the Nth bit is sampled.
    - If si_valid=1 in DONE, that bit is bit 1 of the next frame, so back-to-back frames need no idle gap. Next state is RECV with count=1; otherwise IDLE.
- Gap handling: si_valid=0 in RECV with count<N:
  - GAP_ABORT=1: frame_err=1 next cycle, frame discarded, return to IDLE, no po_valid.
  - GAP_ABORT=0: hold state and count.
- Assembly:
  - MSB-first: shift left, new bit enters bit 0.
  - LSB-first: bit k (0-based) is written to position k.
  - Result occupies po_word[N-1:0].
- Payload recovery:
  - len 00: cfg_low=1 gives {8'h00,w[7:0]}; cfg_low=0 gives {w[7:0],8'h00}.
  - len 01: w[15:0].
  - len 10: fill=1 gives w[23:8] and the pad is w[7:0]; fill=0 gives w[15:0] and the pad is w[23:16].
  - len 11: fill=1 gives w[31:16] and the pad is w[15:0]; fill=0 gives w[15:0] and the pad is w[31:16].
- pad_err: set to the OR of the pad bits for 24/32-bit frames, 0 for 8/16-bit frames.
- po_word, po_data, po_length and pad_err hold their values until the next po_valid.

Test Plan:
- Basic 16-bit MSB-first: len=01, msb=1, bits 1010_0101_1100_0011 on 16 consecutive valid cycles -> po_valid 1 cycle after the 16th bit; po_word=0000A5C3, po_data=A5C3, pad_err=0.
- 8-bit LSB-first, high byte: len=00, msb=0, low=0, bits 1,0,1,0,0,1,0,1 -> po_word=000000A5, po_data=A500.
- 32-bit with padding:
  - len=11, msb=1, fill=1, payload 1234 then 16 zeros -> po_word=12340000, po_data=1234, pad_err=0.
  - Repeat with fill=0 and word 00FF1234 -> po_data=1234, pad_err=1.
- Short frame: len=10, GAP_ABORT=1, si_valid drops after 10 bits -> frame_err pulse 1 cycle, no po_valid, busy=0; the next full frame decodes correctly.
- Back-to-back and gap pause:
  - Two 8-bit frames (0x3C, 0xC3) with no idle cycle -> two po_valid strobes 8 cycles apart, correct values.
  - GAP_ABORT=0 with a 3-cycle gap in a 16-bit frame -> correct word, frame_err never set.
- Reset and config-load priority:
  - reset asserted at bit 7 of a 16-bit frame -> all outputs 0, no strobe; a subsequent frame decodes correctly.
  - cfg_load during RECV is ignored: the frame uses the old length, and the new config takes effect only on the next load in IDLE.

Source files
------------

// File: rtl/sti_deserializer.sv
// STI receive deserializer: samples si_data on si_valid cycles and rebuilds one
// 8/16/24/32-bit frame, then presents word, payload and error flags for one cycle.
module sti_deserializer #(
    parameter bit GAP_ABORT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_load,
    input  logic [1:0]  cfg_length,
    input  logic        cfg_msb,
    input  logic        cfg_fill,
    input  logic        cfg_low,
    input  logic        si_data,
    input  logic        si_valid,
    output logic        busy,
    output logic        po_valid,
    output logic [31:0] po_word,
    output logic [15:0] po_data,
    output logic [1:0]  po_length,
    output logic        pad_err,
    output logic        frame_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [5:0]  count_reg, count_next;
    logic [31:0] shift_reg, shift_next;

    logic [1:0]  len_reg, len_next;
    logic        msb_reg, msb_next;
    logic        fill_reg, fill_next;
    logic        low_reg, low_next;

    logic        po_valid_reg, po_valid_next;
    logic [31:0] po_word_reg, po_word_next;
    logic [15:0] po_data_reg, po_data_next;
    logic [1:0]  po_length_reg, po_length_next;
    logic        pad_err_reg, pad_err_next;
    logic        frame_err_reg, frame_err_next;

    logic [5:0]  frame_bits;
    logic [5:0]  count_inc;
    logic [31:0] lsb_word;
    logic [31:0] assembled;
    logic [15:0] payload;
    logic [15:0] pad_bits;

    assign frame_bits = {1'b0, len_reg, 3'b000} + 6'd8;
    assign count_inc  = count_reg + 6'd1;

    // LSB-first placement: the incoming bit lands at the position given by the
    // number of bits already received, all other positions keep their value.
    for (genvar gi = 0; gi < 32; gi++) begin : g_lsb_place
        assign lsb_word[gi] = (count_reg == 6'(gi)) ? si_data : shift_reg[gi];
    end

    assign assembled = msb_reg ? {shift_reg[30:0], si_data} : lsb_word;

    // Payload and pad extraction from the word as it will stand after this bit.
    always_comb begin
        payload  = 16'h0000;
        pad_bits = 16'h0000;
        case (len_reg)
            2'b00: begin
                payload = low_reg ? {8'h00, assembled[7:0]} : {assembled[7:0], 8'h00};
            end
            2'b01: begin
                payload = assembled[15:0];
            end
            2'b10: begin
                if (fill_reg) begin
                    payload  = assembled[23:8];
                    pad_bits = {8'h00, assembled[7:0]};
                end else begin
                    payload  = assembled[15:0];
                    pad_bits = {8'h00, assembled[23:16]};
                end
            end
            default: begin
                if (fill_reg) begin
                    payload  = assembled[31:16];
                    pad_bits = assembled[15:0];
                end else begin
                    payload  = assembled[15:0];
                    pad_bits = assembled[31:16];
                end
            end
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        shift_next     = shift_reg;
        len_next       = len_reg;
        msb_next       = msb_reg;
        fill_next      = fill_reg;
        low_next       = low_reg;
        po_valid_next  = 1'b0;
        frame_err_next = 1'b0;
        po_word_next   = po_word_reg;
        po_data_next   = po_data_reg;
        po_length_next = po_length_reg;
        pad_err_next   = pad_err_reg;

        case (state_reg)
            IDLE, DONE: begin
                // Config is only accepted between frames; DONE reuses the current one.
                if (state_reg == IDLE && cfg_load) begin
                    len_next  = cfg_length;
                    msb_next  = cfg_msb;
                    fill_next = cfg_fill;
                    low_next  = cfg_low;
                end
                if (si_valid) begin
                    state_next = RECV;
                    count_next = 6'd1;
                    shift_next = {31'd0, si_data};
                end else begin
                    state_next = IDLE;
                    count_next = 6'd0;
                end
            end
            RECV: begin
                if (si_valid) begin
                    shift_next = assembled;
                    count_next = count_inc;
                    if (count_inc == frame_bits) begin
                        state_next     = DONE;
                        po_valid_next  = 1'b1;
                        po_word_next   = assembled;
                        po_data_next   = payload;
                        po_length_next = len_reg;
                        pad_err_next   = |pad_bits;
                    end
                end else if (GAP_ABORT) begin
                    state_next     = IDLE;
                    count_next     = 6'd0;
                    shift_next     = 32'd0;
                    frame_err_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                count_next = 6'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            count_reg     <= 6'd0;
            shift_reg     <= 32'd0;
            len_reg       <= 2'b00;
            msb_reg       <= 1'b0;
            fill_reg      <= 1'b0;
            low_reg       <= 1'b0;
            po_valid_reg  <= 1'b0;
            po_word_reg   <= 32'd0;
            po_data_reg   <= 16'd0;
            po_length_reg <= 2'b00;
            pad_err_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            shift_reg     <= shift_next;
            len_reg       <= len_next;
            msb_reg       <= msb_next;
            fill_reg      <= fill_next;
            low_reg       <= low_next;
            po_valid_reg  <= po_valid_next;
            po_word_reg   <= po_word_next;
            po_data_reg   <= po_data_next;
            po_length_reg <= po_length_next;
            pad_err_reg   <= pad_err_next;
            frame_err_reg <= frame_err_next;
        end
    end

    assign busy      = (state_reg == RECV);
    assign po_valid  = po_valid_reg;
    assign po_word   = po_word_reg;
    assign po_data   = po_data_reg;
    assign po_length = po_length_reg;
    assign pad_err   = pad_err_reg;
    assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_sti_deserializer.sv
// Bench for sti_deserializer: directed framing cases plus randomized frames
// compared against a bit-list reference model; two DUTs cover both gap modes.
module tb_sti_deserializer;

    logic        clk;
    logic        reset;
    logic        cfg_load;
    logic [1:0]  cfg_length;
    logic        cfg_msb;
    logic        cfg_fill;
    logic        cfg_low;
    logic        si_data;
    logic        si_valid;
    logic        use_pause;

    logic        a_busy, a_po_valid, a_pad_err, a_frame_err;
    logic [31:0] a_po_word;
    logic [15:0] a_po_data;
    logic [1:0]  a_po_length;
    logic        b_busy, b_po_valid, b_pad_err, b_frame_err;
    logic [31:0] b_po_word;
    logic [15:0] b_po_data;
    logic [1:0]  b_po_length;

    logic        obs_busy, obs_po_valid, obs_pad_err, obs_frame_err;
    logic [31:0] obs_po_word;
    logic [15:0] obs_po_data;
    logic [1:0]  obs_po_length;

    int checks = 0;
    int failures = 0;

    sti_deserializer #(.GAP_ABORT(1'b1)) dut (
        .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_length(cfg_length),
        .cfg_msb(cfg_msb), .cfg_fill(cfg_fill), .cfg_low(cfg_low),
        .si_data(si_data), .si_valid(si_valid & ~use_pause),
        .busy(a_busy), .po_valid(a_po_valid), .po_word(a_po_word), .po_data(a_po_data),
        .po_length(a_po_length), .pad_err(a_pad_err), .frame_err(a_frame_err)
    );

    sti_deserializer #(.GAP_ABORT(1'b0)) dut_pause (
        .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_length(cfg_length),
        .cfg_msb(cfg_msb), .cfg_fill(cfg_fill), .cfg_low(cfg_low),
        .si_data(si_data), .si_valid(si_valid & use_pause),
        .busy(b_busy), .po_valid(b_po_valid), .po_word(b_po_word), .po_data(b_po_data),
        .po_length(b_po_length), .pad_err(b_pad_err), .frame_err(b_frame_err)
    );

    assign obs_busy      = use_pause ? b_busy      : a_busy;
    assign obs_po_valid  = use_pause ? b_po_valid  : a_po_valid;
    assign obs_po_word   = use_pause ? b_po_word   : a_po_word;
    assign obs_po_data   = use_pause ? b_po_data   : a_po_data;
    assign obs_po_length = use_pause ? b_po_length : a_po_length;
    assign obs_pad_err   = use_pause ? b_pad_err   : a_pad_err;
    assign obs_frame_err = use_pause ? b_frame_err : a_frame_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: a frame is the list of bits in arrival order.
    function automatic logic [31:0] model_word(input logic [31:0] stream, input int n, input bit msb);
        logic [31:0] w;
        w = 32'd0;
        for (int k = 0; k < n; k++)
            if (stream[k]) w = w | (32'd1 << (msb ? (n - 1 - k) : k));
        return w;
    endfunction

    function automatic logic [15:0] model_data(input logic [31:0] w, input int len, input bit fill, input bit low);
        case (len)
            0:       return low ? 16'(w % 256) : 16'((w % 256) * 256);
            1:       return 16'(w % 65536);
            2:       return fill ? 16'((w / 256) % 65536) : 16'(w % 65536);
            default: return fill ? 16'(w / 65536) : 16'(w % 65536);
        endcase
    endfunction

    function automatic bit model_pad(input logic [31:0] w, input int len, input bit fill);
        case (len)
            2:       return fill ? ((w % 256) != 0) : ((w / 65536) != 0);
            3:       return fill ? ((w % 65536) != 0) : ((w / 65536) != 0);
            default: return 1'b0;
        endcase
    endfunction

    // Bit list that transmits 'word' in the requested order.
    function automatic logic [31:0] stream_of(input logic [31:0] word, input int n, input bit msb);
        logic [31:0] s;
        s = 32'd0;
        for (int k = 0; k < n; k++) s[k] = msb ? word[n - 1 - k] : word[k];
        return s;
    endfunction

    task automatic cfg(input int len, input bit msb, input bit fill, input bit low, input bit with_tick);
        cfg_length = 2'(len);
        cfg_msb    = msb;
        cfg_fill   = fill;
        cfg_low    = low;
        cfg_load   = 1'b1;
        if (with_tick) begin
            si_valid = 1'b0;
            tick;
            cfg_load = 1'b0;
        end
    endtask

    task automatic send_bits(input logic [31:0] stream, input int n, input int gap_at, input int gap_len);
        for (int k = 0; k < n; k++) begin
            if (k == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    si_valid = 1'b0;
                    tick;
                    chk("gap_frame_err", 32'(obs_frame_err), 0);
                    chk("gap_busy", 32'(obs_busy), 1);
                end
            end
            si_data  = stream[k];
            si_valid = 1'b1;
            tick;
            cfg_load = 1'b0;
            if (k < n - 1) chk("mid_po_valid", 32'(obs_po_valid), 0);
        end
        si_valid = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [31:0] w, input logic [15:0] d,
                                input int len, input bit p);
        chk({tag, "_po_valid"}, 32'(obs_po_valid), 1);
        chk({tag, "_word"}, obs_po_word, w);
        chk({tag, "_data"}, 32'(obs_po_data), 32'(d));
        chk({tag, "_length"}, 32'(obs_po_length), 32'(len));
        chk({tag, "_pad_err"}, 32'(obs_pad_err), 32'(p));
        chk({tag, "_frame_err"}, 32'(obs_frame_err), 0);
        $display("frame %s word=%h data=%h len=%0d pad_err=%0d", tag, obs_po_word, obs_po_data,
                 obs_po_length, obs_pad_err);
    endtask

    task automatic expect_model(input string tag, input logic [31:0] stream, input int n, input int len,
                                input bit msb, input bit fill, input bit low);
        logic [31:0] w;
        w = model_word(stream, n, msb);
        check_result(tag, w, model_data(w, len, fill, low), len, model_pad(w, len, fill));
    endtask

    task automatic idle_check(input string tag, input logic [31:0] held);
        si_valid = 1'b0;
        tick;
        chk({tag, "_strobe_once"}, 32'(obs_po_valid), 0);
        chk({tag, "_word_held"}, obs_po_word, held);
    endtask

    logic [1:0]  r_len;
    bit          r_msb, r_fill, r_low, r_pause, r_b2b;
    int          r_n;
    logic [31:0] r_w, r_stream;

    initial begin
        reset = 1'b1; cfg_load = 1'b0; cfg_length = 2'b00; cfg_msb = 1'b0;
        cfg_fill = 1'b0; cfg_low = 1'b0; si_data = 1'b0; si_valid = 1'b0; use_pause = 1'b0;
        tick; tick;
        chk("rst_po_valid", 32'(a_po_valid), 0);
        chk("rst_po_word", a_po_word, 0);
        chk("rst_po_data", 32'(a_po_data), 0);
        chk("rst_po_length", 32'(a_po_length), 0);
        chk("rst_pad_err", 32'(a_pad_err), 0);
        chk("rst_frame_err", 32'(a_frame_err), 0);
        chk("rst_busy", 32'(a_busy), 0);
        chk("rst_b_word", b_po_word, 0);
        reset = 1'b0;
        tick;

        // 16-bit MSB-first
        cfg(1, 1, 0, 0, 1);
        send_bits(stream_of(32'hA5C3, 16, 1), 16, -1, 0);
        check_result("msb16", 32'h0000A5C3, 16'hA5C3, 1, 0);
        idle_check("msb16", 32'h0000A5C3);

        // 8-bit LSB-first, high byte
        cfg(0, 0, 0, 0, 1);
        send_bits(32'b1010_0101, 8, -1, 0);
        check_result("lsb8", 32'h000000A5, 16'hA500, 0, 0);
        idle_check("lsb8", 32'h000000A5);

        // 32-bit padding
        cfg(3, 1, 1, 0, 1);
        send_bits(stream_of(32'h12340000, 32, 1), 32, -1, 0);
        check_result("pad32_ok", 32'h12340000, 16'h1234, 3, 0);
        idle_check("pad32_ok", 32'h12340000);
        cfg(3, 1, 0, 0, 1);
        send_bits(stream_of(32'h00FF1234, 32, 1), 32, -1, 0);
        check_result("pad32_err", 32'h00FF1234, 16'h1234, 3, 1);
        idle_check("pad32_err", 32'h00FF1234);

        // Short 24-bit frame aborted by a gap
        cfg(2, 1, 1, 0, 1);
        send_bits(stream_of(32'h00ABCD00, 24, 1), 10, -1, 0);
        chk("short_busy", 32'(obs_busy), 1);
        tick;
        chk("short_frame_err", 32'(obs_frame_err), 1);
        chk("short_po_valid", 32'(obs_po_valid), 0);
        chk("short_busy_after", 32'(obs_busy), 0);
        $display("abort frame_err=%0d po_valid=%0d", obs_frame_err, obs_po_valid);
        tick;
        chk("short_err_pulse", 32'(obs_frame_err), 0);
        send_bits(stream_of(32'h00ABCD00, 24, 1), 24, -1, 0);
        check_result("after_short", 32'h00ABCD00, 16'hABCD, 2, 0);
        idle_check("after_short", 32'h00ABCD00);

        // Back-to-back 8-bit frames
        cfg(0, 1, 0, 1, 1);
        send_bits(stream_of(32'h3C, 8, 1), 8, -1, 0);
        check_result("b2b_first", 32'h3C, 16'h003C, 0, 0);
        send_bits(stream_of(32'hC3, 8, 1), 8, -1, 0);
        check_result("b2b_second", 32'hC3, 16'h00C3, 0, 0);
        idle_check("b2b", 32'hC3);

        // Gap pauses reception
        use_pause = 1'b1;
        cfg(1, 1, 0, 0, 1);
        send_bits(stream_of(32'h5AA5, 16, 1), 16, 5, 3);
        check_result("pause16", 32'h5AA5, 16'h5AA5, 1, 0);
        idle_check("pause16", 32'h5AA5);
        use_pause = 1'b0;

        // Reset mid-frame also clears the configuration
        cfg(1, 1, 0, 0, 1);
        send_bits(stream_of(32'hFFFF, 16, 1), 7, -1, 0);
        reset = 1'b1; si_valid = 1'b1; si_data = 1'b1;
        tick;
        chk("midrst_word", obs_po_word, 0);
        chk("midrst_data", 32'(obs_po_data), 0);
        chk("midrst_busy", 32'(obs_busy), 0);
        chk("midrst_po_valid", 32'(obs_po_valid), 0);
        reset = 1'b0; si_valid = 1'b0;
        tick;
        chk("midrst_no_strobe", 32'(obs_po_valid), 0);
        send_bits(32'b1100_0001, 8, -1, 0);
        check_result("post_rst", 32'hC1, 16'hC100, 0, 0);
        idle_check("post_rst", 32'hC1);

        // cfg_load inside a frame is ignored
        cfg(0, 1, 0, 1, 1);
        r_stream = stream_of(32'h96, 8, 1);
        for (int k = 0; k < 8; k++) begin
            if (k == 3) begin
                cfg_length = 2'b01; cfg_msb = 1'b0; cfg_load = 1'b1;
            end
            si_data = r_stream[k]; si_valid = 1'b1;
            tick;
            cfg_load = 1'b0;
        end
        check_result("ignore_load", 32'h96, 16'h0096, 0, 0);
        idle_check("ignore_load", 32'h96);
        send_bits(stream_of(32'h69, 8, 1), 8, -1, 0);
        check_result("still_old_cfg", 32'h69, 16'h0069, 0, 0);
        idle_check("still_old_cfg", 32'h69);
        cfg(1, 1, 0, 0, 1);
        send_bits(stream_of(32'hBEEF, 16, 1), 16, -1, 0);
        check_result("new_cfg", 32'hBEEF, 16'hBEEF, 1, 0);
        idle_check("new_cfg", 32'hBEEF);

        // Randomized frames
        for (int it = 0; it < 30; it++) begin
            r_len   = 2'($urandom_range(0, 3));
            r_msb   = 1'($urandom_range(0, 1));
            r_fill  = 1'($urandom_range(0, 1));
            r_low   = 1'($urandom_range(0, 1));
            r_pause = 1'($urandom_range(0, 1));
            r_b2b   = ($urandom_range(0, 2) == 0);
            r_n     = 8 * (int'(r_len) + 1);
            r_w     = $urandom;
            if (r_n < 32) r_w = r_w & ((32'd1 << r_n) - 32'd1);
            if (r_len >= 2 && $urandom_range(0, 1) == 1) begin
                if (r_len == 2) r_w = r_w & (r_fill ? 32'h00FFFF00 : 32'h0000FFFF);
                else            r_w = r_w & (r_fill ? 32'hFFFF0000 : 32'h0000FFFF);
            end
            r_stream  = stream_of(r_w, r_n, r_msb);
            use_pause = r_pause;
            cfg(int'(r_len), r_msb, r_fill, r_low, 1'($urandom_range(0, 1)));
            send_bits(r_stream, r_n, r_pause ? int'($urandom_range(1, r_n - 1)) : -1,
                      int'($urandom_range(1, 3)));
            expect_model("rand", r_stream, r_n, int'(r_len), r_msb, r_fill, r_low);
            if (r_b2b) begin
                r_stream = $urandom;
                send_bits(r_stream, r_n, -1, 0);
                expect_model("rand_b2b", r_stream, r_n, int'(r_len), r_msb, r_fill, r_low);
            end
            idle_check("rand", model_word(r_stream, r_n, r_msb));
            use_pause = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
